dm_bridge: RTL and testbench
============================

Name: dm_bridge

Overview:
- Responder end of the core's data-memory port. Services m_data_addr / m_data_wdata / m_data_byteen and returns m_data_rdata in the same cycle.
- Decodes the address into two targets:
  - a word-organised data RAM with byte-lane writes;
  - a memory-mapped countdown timer (CTRL / PRESET / COUNT) that raises an interrupt line.
- Sits outside the core, alongside the instruction memory, in the system top.

Parameters:
- DM_WORDS, 3072: data RAM depth in 32-bit words. Covers 0x0000..(4*DM_WORDS-1).
- TC_BASE, 32'h0000_7F00: base byte address of the timer. Register offsets: CTRL +0x0, PRESET +0x4, COUNT +0x8.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_data_addr  in  32  byte address from the core MEM stage.
- m_data_wdata  in  32  write data, already lane-aligned by the core.
- m_data_byteen  in  4  byte write enables. 4'b0000 means the access is a read or idle.
- m_inst_addr  in  32  PC of the instruction in MEM. Used only for the write log.
- m_data_rdata  out  32  read data, combinational from address.
- irq  out  1  timer interrupt request.
- bus_err  out  1  registered one-cycle pulse on an access outside both regions.

Behaviour:
- Address decode:
  - DM hit: m_data_addr < 4*DM_WORDS.
  - TC hit: m_data_addr[31:4] == TC_BASE[31:4] and m_data_addr[3:2] != 2'b11.
  - Anything else misses. addr[1:0] is ignored for word select.
- Reads:
  - m_data_rdata is purely combinational; no read latency.
  - DM hit returns mem[addr>>2].
  - TC hit returns the selected register. CTRL reads as {28'b0, CTRL[3:0]}.
  - A miss returns 32'h0.
- Writes:
  - Occur on the rising edge when byteen != 0.
  - Each lane i with byteen[i]=1 replaces byte i; other bytes are unchanged.
  - A DM hit writes the RAM. A TC hit writes CTRL or PRESET. Writes to COUNT are ignored.
- bus_err is registered and pulses for 1 cycle after a miss with byteen != 0. It also pulses after a miss where a read is implied: addr != 0 and byteen == 0. Address 0 with byteen 0 is the idle bus and does not raise bus_err.
- CTRL bits:
  - [0] EN: counter enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload; 1x is treated as 00.
  - [3] IM: interrupt mask; 1 = irq allowed.
- Timer FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: go to LOAD when EN=1.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT:
    - If EN=0, go to IDLE; COUNT holds.
    - Else if COUNT==0, go to INT.
    - Else COUNT <= COUNT-1.
  - INT: set int_flag.
    - MODE 00: clear EN, go to IDLE.
    - MODE 01: go to IDLE, which reloads on the next cycle because EN is still 1.
  - With PRESET=N, the counter enters INT N+1 cycles after entering CNT. PRESET=0 reaches INT on the cycle after LOAD.
- irq = int_flag & CTRL[3]. int_flag is cleared by any write hitting CTRL.
- Simultaneous events:
  - A bus write to CTRL in the same cycle as the FSM clearing EN in INT: the bus write wins.
  - A write to CTRL in the same cycle as entering INT: int_flag ends up clear.
  - A PRESET write while in CNT does not affect the running count; it takes effect at the next LOAD.
- Reset (asynchronous, active-low):
  - RAM: contents are not cleared.
  - Registers: CTRL=0, PRESET=0, COUNT=0, state=IDLE, int_flag=0.
  - Outputs: irq=0, bus_err=0. m_data_rdata follows decode: 0 at address 0 returns mem[0].
- Reset asserted mid-count aborts the count immediately.

Optional Feature:
- DM_WRITE_LOG_EN defined: every committed write with byteen != 0 prints one line at the clock edge:
  - format "@%h: *%h <= %h";
  - fields are the PC, the word-aligned address, and the merged 32-bit word.
  - DM and TC writes are both logged; misses are not.
- Not defined: no simulation output. Logic is otherwise identical.

Test Plan:
- sw 0x12345678 to 0x0010 (byteen 1111), then sb 0xAB in lane 2 to 0x0012 (byteen 0100) -> reading 0x0010 returns 0x12AB5678.
- Read 0x0010 in the same cycle the address is presented -> m_data_rdata equals stored word with zero latency. Write to 0x0000_3000 with DM_WORDS=3072 -> bus_err pulses 1 cycle; RAM unchanged.
- PRESET=3, then CTRL=4'b1001 (IM, one-shot, EN) -> COUNT reads 3,2,1,0; INT is entered 4 cycles after CNT starts; irq=1 and stays high. CTRL reads 4'b1000. Writing CTRL=0 drops irq next cycle.
- PRESET=2, CTRL=4'b1011 (auto-reload) -> irq asserts periodically, every 6 cycles: LOAD, 3 CNT, INT, IDLE. COUNT reloads to 2 each period. With IM=0, irq stays 0.
- Mid-count write of PRESET=9 while COUNT=5 -> count continues 4,3,...; the next reload loads 9. Clearing EN mid-count -> IDLE, COUNT frozen.
- Assert reset while in CNT with COUNT=7 -> asynchronously CTRL=PRESET=COUNT=0, irq=0, state IDLE. After release the timer stays idle, and a previously written RAM word is still readable.

Source files
------------

// File: rtl/dm_bridge.sv
// Data-memory responder: word RAM with byte-lane writes plus a memory-mapped countdown timer.
// Define DM_WRITE_LOG_EN to print one line per committed write (simulation only).
module dm_bridge #(
   parameter int unsigned DM_WORDS = 3072,
   parameter logic [31:0] TC_BASE  = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m_data_addr,
   input  logic [31:0] m_data_wdata,
   input  logic [3:0]  m_data_byteen,
   input  logic [31:0] m_inst_addr,
   output logic [31:0] m_data_rdata,
   output logic        irq,
   output logic        bus_err
);

   localparam int unsigned AW       = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
   localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

   typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} tc_state_e;

   logic [31:0] mem [DM_WORDS];

   tc_state_e   state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        int_flag_q, int_flag_d;
   logic        bus_err_q, bus_err_d;

   logic          dm_hit, tc_hit, wr_en, ctrl_wr, preset_wr;
   logic [AW-1:0] word_idx;
   logic [31:0]   rd_word, wr_word;

   assign dm_hit   = m_data_addr < DM_BYTES;
   assign tc_hit   = (m_data_addr[31:4] == TC_BASE[31:4]) && (m_data_addr[3:2] != 2'b11);
   assign wr_en    = |m_data_byteen;
   assign word_idx = m_data_addr[AW+1:2];

   // DM takes priority should a parameterisation ever overlap the two regions.
   assign ctrl_wr   = wr_en && !dm_hit && tc_hit && (m_data_addr[3:2] == 2'b00);
   assign preset_wr = wr_en && !dm_hit && tc_hit && (m_data_addr[3:2] == 2'b01);

   always_comb begin
      rd_word = '0;
      if (dm_hit) begin
         rd_word = mem[word_idx];
      end else if (tc_hit) begin
         case (m_data_addr[3:2])
            2'b00:   rd_word = {28'b0, ctrl_q};
            2'b01:   rd_word = preset_q;
            2'b10:   rd_word = count_q;
            default: rd_word = '0;
         endcase
      end
   end

   assign m_data_rdata = rd_word;

   // Current word with the enabled lanes replaced: the value a write commits.
   always_comb begin
      wr_word = rd_word;
      for (int i = 0; i < 4; i++) begin
         if (m_data_byteen[i]) wr_word[8*i +: 8] = m_data_wdata[8*i +: 8];
      end
   end

   // RAM is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en && dm_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) mem[word_idx][8*i +: 8] <= m_data_wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      int_flag_d = int_flag_q;
      case (state_q)
         StIdle: if (ctrl_q[0]) state_d = StLoad;
         StLoad: begin
            count_d = preset_q;
            state_d = StCnt;
         end
         StCnt: begin
            if (!ctrl_q[0])          state_d = StIdle;
            else if (count_q == '0)  state_d = StInt;
            else                     count_d = count_q - 32'd1;
         end
         StInt: begin
            int_flag_d = 1'b1;
            if (ctrl_q[2:1] != 2'b01) ctrl_d[0] = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // A bus write to CTRL overrides both the FSM's EN clear and a same-cycle flag set.
      if (ctrl_wr) begin
         ctrl_d     = wr_word[3:0];
         int_flag_d = 1'b0;
      end
      if (preset_wr) preset_d = wr_word;
   end

   assign bus_err_d = !dm_hit && !tc_hit && (wr_en || (m_data_addr != '0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         int_flag_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         int_flag_q <= int_flag_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign irq     = int_flag_q & ctrl_q[3];
   assign bus_err = bus_err_q;

`ifdef DM_WRITE_LOG_EN
   always_ff @(posedge clk) begin
      if (reset && wr_en && (dm_hit || tc_hit)) begin
         $display("@%h: *%h <= %h", m_inst_addr, {m_data_addr[31:2], 2'b00}, wr_word);
      end
   end
`else
   logic unused_inst_addr;
   assign unused_inst_addr = ^m_inst_addr;
`endif

endmodule

// File: tb/tb_dm_bridge.sv
// Directed bench for dm_bridge: table-driven RAM/decode vectors plus timer sequences.
module tb_dm_bridge;

   logic        clk;
   logic        reset;
   logic [31:0] m_data_addr;
   logic [31:0] m_data_wdata;
   logic [3:0]  m_data_byteen;
   logic [31:0] m_inst_addr;
   logic [31:0] m_data_rdata;
   logic        irq;
   logic        bus_err;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
   localparam logic [31:0] A_PRESET = 32'h0000_7F04;
   localparam logic [31:0] A_COUNT  = 32'h0000_7F08;

   dm_bridge dut (
      .clk           (clk),
      .reset         (reset),
      .m_data_addr   (m_data_addr),
      .m_data_wdata  (m_data_wdata),
      .m_data_byteen (m_data_byteen),
      .m_inst_addr   (m_inst_addr),
      .m_data_rdata  (m_data_rdata),
      .irq           (irq),
      .bus_err       (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        chk_rd;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t vecs [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      m_data_addr   = a;
      m_data_wdata  = d;
      m_data_byteen = be;
      m_inst_addr   = 32'h0000_3000 + a;
      step();
      m_data_addr   = '0;
      m_data_wdata  = '0;
      m_data_byteen = '0;
   endtask

   task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      m_data_addr = a;
      #1;
      check(name, m_data_rdata, exp);
   endtask

   int exp_cnt_a [1:7] = '{0, 3, 2, 1, 0, 0, 0};
   int exp_irq_a [1:7] = '{0, 0, 0, 0, 0, 0, 1};
   int exp_cnt_b [1:6] = '{0, 2, 1, 0, 0, 0};
   int exp_irq_b [1:6] = '{0, 0, 0, 0, 0, 1};
   int exp_cnt_c [6:13] = '{3, 2, 1, 0, 0, 0, 0, 9};

   initial begin
      reset         = 1'b0;
      m_data_addr   = A_CTRL;
      m_data_wdata  = '0;
      m_data_byteen = '0;
      m_inst_addr   = '0;
      #3;
      check("reset_ctrl", m_data_rdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      check("reset_bus_err", {31'b0, bus_err}, 32'h0);
      rd_check("reset_count", A_COUNT, 32'h0);
      rd_check("reset_preset", A_PRESET, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset       = 1'b1;
      m_data_addr = '0;
      step();

      // {addr, wdata, byteen, check read, pre-edge read, bus_err after edge}
      vecs.push_back('{32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0,          1'b0});
      vecs.push_back('{32'h0000_0010, 32'h1234_5678, 4'b1111, 1'b0, 32'h0,          1'b0});
      vecs.push_back('{32'h0000_0012, 32'h00AB_0000, 4'b0100, 1'b0, 32'h0,          1'b0});
      vecs.push_back('{32'h0000_0010, 32'h0,         4'b0000, 1'b1, 32'h12AB_5678, 1'b0});
      vecs.push_back('{32'h0000_0014, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,          1'b0});
      vecs.push_back('{32'h0000_0014, 32'h0000_0011, 4'b0001, 1'b0, 32'h0,          1'b0});
      vecs.push_back('{32'h0000_0017, 32'h2200_0000, 4'b1000, 1'b0, 32'h0,          1'b0});
      vecs.push_back('{32'h0000_0016, 32'h0,         4'b0000, 1'b1, 32'h22AD_BE11, 1'b0});
      vecs.push_back('{32'h0000_2FFC, 32'hA5A5_A5A5, 4'b1111, 1'b0, 32'h0,          1'b0});
      vecs.push_back('{32'h0000_2FFC, 32'h0,         4'b0000, 1'b1, 32'hA5A5_A5A5, 1'b0});
      vecs.push_back('{32'h0000_3000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0,          1'b1});
      vecs.push_back('{32'h0000_0000, 32'h0,         4'b0000, 1'b1, 32'hCAFE_F00D, 1'b0});
      vecs.push_back('{32'h0000_4000, 32'h0,         4'b0000, 1'b1, 32'h0,          1'b1});
      vecs.push_back('{32'h0000_7F0C, 32'h0,         4'b0000, 1'b1, 32'h0,          1'b1});
      vecs.push_back('{A_PRESET,      32'h0000_0005, 4'b1111, 1'b1, 32'h0,          1'b0});
      vecs.push_back('{32'h0000_7F05, 32'h0000_AA00, 4'b0010, 1'b1, 32'h0000_0005, 1'b0});
      vecs.push_back('{A_PRESET,      32'h0,         4'b0000, 1'b1, 32'h0000_AA05, 1'b0});
      vecs.push_back('{A_CTRL,        32'hFFFF_FFF6, 4'b1111, 1'b1, 32'h0,          1'b0});
      vecs.push_back('{A_CTRL,        32'h0,         4'b0000, 1'b1, 32'h0000_0006, 1'b0});
      vecs.push_back('{A_COUNT,       32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0,          1'b0});
      vecs.push_back('{A_COUNT,       32'h0,         4'b0000, 1'b1, 32'h0,          1'b0});
      vecs.push_back('{A_CTRL,        32'h0,         4'b1111, 1'b1, 32'h0000_0006, 1'b0});

      foreach (vecs[i]) begin
         m_data_addr   = vecs[i].addr;
         m_data_wdata  = vecs[i].wdata;
         m_data_byteen = vecs[i].be;
         m_inst_addr   = 32'h0000_3000 + 32'(i * 4);
         #1;
         if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), m_data_rdata, vecs[i].rd);
         step();
         check($sformatf("vec%0d_bus_err", i), {31'b0, bus_err}, {31'b0, vecs[i].err});
      end
      m_data_addr   = '0;
      m_data_byteen = '0;
      m_data_wdata  = '0;
      step();

      // One-shot: PRESET=3, CTRL=IM|EN
      bus_write(A_PRESET, 32'd3, 4'b1111);
      bus_write(A_CTRL, 32'h9, 4'b1111);
      m_data_addr = A_COUNT;
      for (int k = 1; k <= 7; k++) begin
         step();
         check($sformatf("oneshot_count_e%0d", k), m_data_rdata, 32'(exp_cnt_a[k]));
         check($sformatf("oneshot_irq_e%0d", k), {31'b0, irq}, 32'(exp_irq_a[k]));
      end
      rd_check("oneshot_ctrl_en_cleared", A_CTRL, 32'h8);
      step();
      check("oneshot_irq_sticky", {31'b0, irq}, 32'h1);
      bus_write(A_CTRL, 32'h0, 4'b1111);
      check("oneshot_irq_cleared", {31'b0, irq}, 32'h0);
      step();

      // Auto-reload: PRESET=2, CTRL=IM|MODE01|EN, 6-cycle period
      bus_write(A_PRESET, 32'd2, 4'b1111);
      bus_write(A_CTRL, 32'hB, 4'b1111);
      m_data_addr = A_COUNT;
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("reload_count_e%0d", k), m_data_rdata, 32'(exp_cnt_b[k]));
         check($sformatf("reload_irq_e%0d", k), {31'b0, irq}, 32'(exp_irq_b[k]));
      end
      bus_write(A_CTRL, 32'hB, 4'b1111);
      check("reload_irq_ack", {31'b0, irq}, 32'h0);
      m_data_addr = A_COUNT;
      for (int k = 8; k <= 12; k++) begin
         step();
         if (k == 8) check("reload_count_reloaded", m_data_rdata, 32'd2);
         check($sformatf("reload_irq_e%0d", k), {31'b0, irq}, (k == 12) ? 32'h1 : 32'h0);
      end
      bus_write(A_CTRL, 32'h3, 4'b1111);
      m_data_addr = A_COUNT;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 1) check("nomask_count_reloaded", m_data_rdata, 32'd2);
         check($sformatf("nomask_irq_c%0d", k), {31'b0, irq}, 32'h0);
      end
      bus_write(A_CTRL, 32'h0, 4'b1111);
      repeat (3) step();

      // PRESET write mid-count, then EN cleared mid-count
      bus_write(A_PRESET, 32'd7, 4'b1111);
      bus_write(A_CTRL, 32'h3, 4'b1111);
      m_data_addr = A_COUNT;
      step();
      step();
      check("midpreset_count_e2", m_data_rdata, 32'd7);
      step();
      step();
      check("midpreset_count_e4", m_data_rdata, 32'd5);
      bus_write(A_PRESET, 32'd9, 4'b1111);
      rd_check("midpreset_count_e5", A_COUNT, 32'd4);
      for (int k = 6; k <= 13; k++) begin
         step();
         check($sformatf("midpreset_count_e%0d", k), m_data_rdata, 32'(exp_cnt_c[k]));
      end
      step();
      check("midpreset_count_e14", m_data_rdata, 32'd8);
      bus_write(A_CTRL, 32'h0, 4'b1111);
      rd_check("stop_count_e15", A_COUNT, 32'd7);
      for (int k = 16; k <= 18; k++) begin
         step();
         check($sformatf("stop_count_frozen_e%0d", k), m_data_rdata, 32'd7);
      end
      rd_check("stop_preset", A_PRESET, 32'd9);

      // Reset asserted mid-count
      bus_write(A_PRESET, 32'd10, 4'b1111);
      bus_write(A_CTRL, 32'h9, 4'b1111);
      m_data_addr = A_COUNT;
      repeat (5) step();
      check("prereset_count", m_data_rdata, 32'd7);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_count", m_data_rdata, 32'h0);
      check("async_reset_irq", {31'b0, irq}, 32'h0);
      check("async_reset_bus_err", {31'b0, bus_err}, 32'h0);
      rd_check("async_reset_ctrl", A_CTRL, 32'h0);
      rd_check("async_reset_preset", A_PRESET, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      m_data_addr = A_COUNT;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("postreset_count_c%0d", k), m_data_rdata, 32'h0);
      end
      check("postreset_irq", {31'b0, irq}, 32'h0);
      rd_check("postreset_ram_kept", 32'h0000_0010, 32'h12AB_5678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
